fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, meaning RAM address width; depth = 2^ADDR_WIDTH; legal 2..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flops in the wptr synchronizer; legal 2..4.
REQ-003 SHALL have parameter AE_LEVEL, default 1, meaning almost-empty threshold in entries; legal 0..2^ADDR_WIDTH.
REQ-004 SHALL have port clk  in  1  read-domain clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port inc  in  1  read request from consumer.
REQ-007 SHALL have port wptr  in  ADDR_WIDTH+1  Gray-coded write pointer from write domain, asynchronous to clk.
REQ-008 SHALL have port clr_err  in  1  clears sticky underflow.
REQ-009 SHALL have port raddr  out  ADDR_WIDTH  RAM read address.
REQ-010 SHALL have port rd_en  out  1  accepted read strobe to RAM.
REQ-011 SHALL have port rptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer to write domain.
REQ-012 SHALL have port empty  out  1  FIFO empty.
REQ-013 SHALL have port almost_empty  out  1  occupancy <= AE_LEVEL.
REQ-014 SHALL have port rd_count  out  ADDR_WIDTH+1  occupancy as seen by read domain, 0..2^ADDR_WIDTH.
REQ-015 SHALL have port underflow  out  1  sticky: read attempted while empty.

Function
REQ-016 SHALL pass wptr through a SYNC_STAGES-deep flop chain; wptr_s = last stage; no logic between stages.
REQ-017 SHALL drive rd_en = inc & !empty, combinational.
REQ-018 SHALL hold binary pointer rptr (ADDR_WIDTH+1 bits): +1 on edge when rd_en=1, else hold; wraps all-ones -> 0.
REQ-019 SHALL drive raddr = rptr[ADDR_WIDTH-1:0], combinational.
REQ-020 SHALL register rptr_gray = bin2gray(rptr_next) on the same edge rptr updates (no one-cycle Gray lag); bin2gray(b) = b ^ (b >> 1), generic for any width, no lookup table.
REQ-021 SHALL drive empty = (rptr_gray == wptr_s), combinational from registers only.
REQ-022 SHALL drive rd_count = (gray2bin(wptr_s) - rptr) modulo 2^(ADDR_WIDTH+1); gray2bin is prefix-XOR from MSB.
REQ-023 SHALL drive almost_empty = (rd_count <= AE_LEVEL); empty implies almost_empty.
REQ-024 SHALL set underflow on edge where inc=1 and empty=1; rptr unchanged on that edge.
REQ-025 SHALL clear underflow on edge where clr_err=1 and no new underflow; simultaneous set and clear -> set wins.
REQ-026 SHALL give write-to-visible latency of SYNC_STAGES clk edges from a stable wptr change to empty/rd_count update.
REQ-027 SHALL treat wptr change and accepted read on same edge independently; both reflected after their respective latencies, no lost read.
REQ-028 SHALL report full occupancy as rd_count = 2^ADDR_WIDTH (pointers differ only in MSB) with empty=0.
REQ-029 SHALL make rd_count out of legal range (corrupt wptr) unspecified; no saturation logic required.

Reset
REQ-030 SHALL, while rst=0, force immediately (no clock) all sync stages, rptr, rptr_gray, underflow to 0.
REQ-031 SHALL thus present during reset: raddr=0, rptr_gray=0, empty=1, almost_empty=1, rd_count=0, rd_en=0, underflow=0.
REQ-032 SHALL accept reset assertion mid-operation at any point; in-flight read on that edge is discarded.

Verification (ADDR_WIDTH=3, SYNC_STAGES=2, AE_LEVEL=1 unless stated)
REQ-033 SHALL verify reset: rst=0 with rptr=5 between edges -> outputs per REQ-031 without a clk edge.
REQ-034 SHALL verify sync/read: wptr=0011 held -> after 2 edges empty=0, rd_count=2, almost_empty=0; inc 1 cycle -> raddr=1, rptr_gray=0001, rd_count=1, almost_empty=1; inc again -> rptr_gray=0011, empty=1.
REQ-035 SHALL verify underflow: empty, inc=1 one cycle -> rptr unchanged, underflow=1 held; clr_err=1 -> 0; clr_err with inc&empty same edge -> stays 1.
REQ-036 SHALL verify full and wrap: wptr=1100 (bin 8), rptr=0 -> rd_count=8, empty=0; 8 reads -> raddr 7->0, rptr_gray 0100->1100; 16 reads total -> rptr=0, each rptr_gray = b^(b>>1).
REQ-037 SHALL verify parameter sweep ADDR_WIDTH=4, SYNC_STAGES=3, AE_LEVEL=4: 3-edge latency, 32-read wrap, almost_empty toggles at rd_count 5->4.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: synchronizes the Gray write
// pointer into the read clock domain and tracks the read pointer, occupancy and underflow.
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AE_LEVEL    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH:0]   rptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] AE_CNT = PW'(AE_LEVEL);

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH:0] wptr_s;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] rptr_next;

    // Plain flop chain; each stage only re-times the previous one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wptr_s = sync_q[SYNC_STAGES-1];

    // Handshake: the consumer raises inc whenever it wants a word; a word is
    // taken exactly on edges where rd_en (inc & !empty) is high. inc while
    // empty is refused and flagged as underflow.
    assign rd_en     = inc & ~empty;
    assign rptr_next = rptr + {{ADDR_WIDTH{1'b0}}, rd_en};

    // Gray is registered from rptr_next so both pointers move on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr      <= '0;
            rptr_gray <= '0;
        end else begin
            rptr      <= rptr_next;
            rptr_gray <= bin2gray(rptr_next);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow <= 1'b0;
        end else if (inc && empty) begin
            underflow <= 1'b1;
        end else if (clr_err) begin
            underflow <= 1'b0;
        end
    end

    assign raddr        = rptr[ADDR_WIDTH-1:0];
    assign empty        = (rptr_gray == wptr_s);
    assign rd_count     = gray2bin(wptr_s) - rptr;
    assign almost_empty = (rd_count <= AE_CNT);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a default instance plus a
// wider instance (ADDR_WIDTH=4, SYNC_STAGES=3, AE_LEVEL=4).
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rst;
    logic       a_inc, a_clr;
    logic [3:0] a_wptr;
    logic [2:0] a_raddr;
    logic       a_rd_en, a_empty, a_ae, a_uf;
    logic [3:0] a_gray, a_count;
    logic       b_inc, b_clr;
    logic [4:0] b_wptr;
    logic [3:0] b_raddr;
    logic       b_rd_en, b_empty, b_ae, b_uf;
    logic [4:0] b_gray, b_count;

    int checks   = 0;
    int failures = 0;

    fifo_rd_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .AE_LEVEL(1)) dut_a (
        .clk(clk), .rst(rst), .inc(a_inc), .wptr(a_wptr), .clr_err(a_clr),
        .raddr(a_raddr), .rd_en(a_rd_en), .rptr_gray(a_gray), .empty(a_empty),
        .almost_empty(a_ae), .rd_count(a_count), .underflow(a_uf)
    );

    fifo_rd_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(3), .AE_LEVEL(4)) dut_b (
        .clk(clk), .rst(rst), .inc(b_inc), .wptr(b_wptr), .clr_err(b_clr),
        .raddr(b_raddr), .rd_en(b_rd_en), .rptr_gray(b_gray), .empty(b_empty),
        .almost_empty(b_ae), .rd_count(b_count), .underflow(b_uf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; a_inc = 1'b1; b_inc = 1'b1; a_clr = 1'b0; b_clr = 1'b0;
        a_wptr = '0; b_wptr = '0;
        step(); step();
        checks++; if (a_raddr !== 3'd0) begin failures++; $display("FAIL rst_raddr got=%0h exp=0", a_raddr); end
        checks++; if (a_gray !== 4'd0) begin failures++; $display("FAIL rst_gray got=%0h exp=0", a_gray); end
        checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", a_empty); end
        checks++; if (a_ae !== 1'b1) begin failures++; $display("FAIL rst_ae got=%0b exp=1", a_ae); end
        checks++; if (a_count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0h exp=0", a_count); end
        checks++; if (a_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%0b exp=0", a_rd_en); end
        checks++; if (a_uf !== 1'b0) begin failures++; $display("FAIL rst_uf got=%0b exp=0", a_uf); end
        checks++; if (b_empty !== 1'b1 || b_rd_en !== 1'b0) begin failures++; $display("FAIL rst_b got=%0b%0b exp=10", b_empty, b_rd_en); end
        a_inc = 1'b0; b_inc = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_sync_read();
        a_wptr = 4'b0011;
        step();
        checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL sync_lat1_empty got=%0b exp=1", a_empty); end
        step();
        checks++; if (a_empty !== 1'b0) begin failures++; $display("FAIL sync_empty got=%0b exp=0", a_empty); end
        checks++; if (a_count !== 4'd2) begin failures++; $display("FAIL sync_count got=%0d exp=2", a_count); end
        checks++; if (a_ae !== 1'b0) begin failures++; $display("FAIL sync_ae got=%0b exp=0", a_ae); end
        a_inc = 1'b1;
        #1;
        checks++; if (a_rd_en !== 1'b1) begin failures++; $display("FAIL read_rd_en got=%0b exp=1", a_rd_en); end
        step();
        a_inc = 1'b0;
        checks++; if (a_raddr !== 3'd1) begin failures++; $display("FAIL read1_raddr got=%0d exp=1", a_raddr); end
        checks++; if (a_gray !== 4'b0001) begin failures++; $display("FAIL read1_gray got=%b exp=0001", a_gray); end
        checks++; if (a_count !== 4'd1) begin failures++; $display("FAIL read1_count got=%0d exp=1", a_count); end
        checks++; if (a_ae !== 1'b1 || a_empty !== 1'b0) begin failures++; $display("FAIL read1_ae_empty got=%0b%0b exp=10", a_ae, a_empty); end
        a_inc = 1'b1;
        step();
        a_inc = 1'b0;
        checks++; if (a_gray !== 4'b0011) begin failures++; $display("FAIL read2_gray got=%b exp=0011", a_gray); end
        checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL read2_empty got=%0b exp=1", a_empty); end
        checks++; if (a_raddr !== 3'd2 || a_count !== 4'd0) begin failures++; $display("FAIL read2_addr_count got=%0d/%0d exp=2/0", a_raddr, a_count); end
    endtask

    task automatic test_underflow();
        a_inc = 1'b1;
        #1;
        checks++; if (a_rd_en !== 1'b0) begin failures++; $display("FAIL uf_rd_en got=%0b exp=0", a_rd_en); end
        step();
        a_inc = 1'b0;
        checks++; if (a_uf !== 1'b1) begin failures++; $display("FAIL uf_set got=%0b exp=1", a_uf); end
        checks++; if (a_raddr !== 3'd2 || a_gray !== 4'b0011) begin failures++; $display("FAIL uf_ptr_hold got=%0d/%b exp=2/0011", a_raddr, a_gray); end
        step();
        checks++; if (a_uf !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0b exp=1", a_uf); end
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        checks++; if (a_uf !== 1'b0) begin failures++; $display("FAIL uf_clear got=%0b exp=0", a_uf); end
        a_inc = 1'b1;
        step();
        checks++; if (a_uf !== 1'b1) begin failures++; $display("FAIL uf_reset got=%0b exp=1", a_uf); end
        a_clr = 1'b1;
        step();
        a_inc = 1'b0; a_clr = 1'b0;
        checks++; if (a_uf !== 1'b1) begin failures++; $display("FAIL uf_set_wins got=%0b exp=1", a_uf); end
        checks++; if (a_raddr !== 3'd2) begin failures++; $display("FAIL uf_raddr got=%0d exp=2", a_raddr); end
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        checks++; if (a_uf !== 1'b0) begin failures++; $display("FAIL uf_clear2 got=%0b exp=0", a_uf); end
    endtask

    task automatic test_full_wrap();
        logic [3:0] mb;
        logic [3:0] eg;
        mb = '0;
        rst = 1'b0; a_wptr = 4'b1100;
        #1;
        rst = 1'b1;
        step(); step();
        checks++; if (a_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", a_count); end
        checks++; if (a_empty !== 1'b0 || a_ae !== 1'b0) begin failures++; $display("FAIL full_flags got=%0b%0b exp=00", a_empty, a_ae); end
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 8; k++) begin
                checks++; if (a_raddr !== mb[2:0]) begin failures++; $display("FAIL wrap_raddr got=%0d exp=%0d", a_raddr, mb[2:0]); end
                a_inc = 1'b1;
                step();
                mb = mb + 4'd1;
                eg = mb ^ (mb >> 1);
                checks++; if (a_gray !== eg) begin failures++; $display("FAIL wrap_gray got=%b exp=%b", a_gray, eg); end
                checks++; if (a_count !== 4'(7 - k)) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", a_count, 7 - k); end
            end
            a_inc = 1'b0;
            checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%0b exp=1", a_empty); end
            if (h == 0) begin
                checks++; if (a_gray !== 4'b1100) begin failures++; $display("FAIL wrap_half_gray got=%b exp=1100", a_gray); end
                a_wptr = 4'b0000;
                step(); step();
                checks++; if (a_count !== 4'd8 || a_empty !== 1'b0) begin failures++; $display("FAIL wrap_refill got=%0d/%0b exp=8/0", a_count, a_empty); end
            end
        end
        checks++; if (a_gray !== 4'b0000 || a_raddr !== 3'd0) begin failures++; $display("FAIL wrap_end got=%b/%0d exp=0000/0", a_gray, a_raddr); end
    endtask

    task automatic test_back_to_back();
        a_wptr = 4'b0011;
        step(); step();
        checks++; if (a_count !== 4'd2) begin failures++; $display("FAIL b2b_start got=%0d exp=2", a_count); end
        a_inc = 1'b1; a_wptr = 4'b0110;
        step();
        checks++; if (a_count !== 4'd1 || a_raddr !== 3'd1) begin failures++; $display("FAIL b2b_edge1 got=%0d/%0d exp=1/1", a_count, a_raddr); end
        step();
        a_inc = 1'b0;
        checks++; if (a_count !== 4'd2 || a_raddr !== 3'd2) begin failures++; $display("FAIL b2b_edge2 got=%0d/%0d exp=2/2", a_count, a_raddr); end
        step();
        checks++; if (a_count !== 4'd2 || a_empty !== 1'b0) begin failures++; $display("FAIL b2b_hold got=%0d/%0b exp=2/0", a_count, a_empty); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; a_wptr = 4'b0101;
        #1;
        rst = 1'b1;
        step(); step();
        a_inc = 1'b1;
        repeat (5) step();
        checks++; if (a_raddr !== 3'd5 || a_gray !== 4'b0111) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=5/0111", a_raddr, a_gray); end
        checks++; if (a_count !== 4'd1) begin failures++; $display("FAIL mid_count got=%0d exp=1", a_count); end
        rst = 1'b0;
        #1;
        checks++; if (a_raddr !== 3'd0 || a_gray !== 4'd0) begin failures++; $display("FAIL mid_rst_ptr got=%0d/%b exp=0/0000", a_raddr, a_gray); end
        checks++; if (a_empty !== 1'b1 || a_ae !== 1'b1 || a_count !== 4'd0) begin failures++; $display("FAIL mid_rst_flags got=%0b%0b/%0d exp=11/0", a_empty, a_ae, a_count); end
        checks++; if (a_rd_en !== 1'b0 || a_uf !== 1'b0) begin failures++; $display("FAIL mid_rst_en_uf got=%0b%0b exp=00", a_rd_en, a_uf); end
        step();
        checks++; if (a_raddr !== 3'd0 || a_uf !== 1'b0) begin failures++; $display("FAIL mid_rst_hold got=%0d/%0b exp=0/0", a_raddr, a_uf); end
        a_inc = 1'b0; a_wptr = 4'b0000;
        rst = 1'b1;
    endtask

    task automatic test_param_sweep();
        logic [4:0] mb;
        logic [4:0] eg;
        mb = '0;
        rst = 1'b0; b_wptr = '0;
        #1;
        rst = 1'b1;
        b_wptr = 5'b00111;
        step(); step();
        checks++; if (b_empty !== 1'b1) begin failures++; $display("FAIL sw_lat2_empty got=%0b exp=1", b_empty); end
        step();
        checks++; if (b_empty !== 1'b0 || b_count !== 5'd5) begin failures++; $display("FAIL sw_lat3 got=%0b/%0d exp=0/5", b_empty, b_count); end
        checks++; if (b_ae !== 1'b0) begin failures++; $display("FAIL sw_ae5 got=%0b exp=0", b_ae); end
        b_inc = 1'b1;
        step();
        b_inc = 1'b0;
        mb = mb + 5'd1;
        checks++; if (b_count !== 5'd4 || b_ae !== 1'b1) begin failures++; $display("FAIL sw_ae4 got=%0d/%0b exp=4/1", b_count, b_ae); end
        b_wptr = 5'b11000;
        repeat (3) step();
        checks++; if (b_count !== 5'd15) begin failures++; $display("FAIL sw_count15 got=%0d exp=15", b_count); end
        for (int k = 0; k < 31; k++) begin
            if (k == 15) begin
                b_inc = 1'b0;
                checks++; if (b_gray !== 5'b11000 || b_raddr !== 4'd0 || b_empty !== 1'b1) begin failures++; $display("FAIL sw_half got=%b/%0d/%0b exp=11000/0/1", b_gray, b_raddr, b_empty); end
                b_wptr = 5'b00000;
                repeat (3) step();
                checks++; if (b_count !== 5'd16 || b_empty !== 1'b0) begin failures++; $display("FAIL sw_full got=%0d/%0b exp=16/0", b_count, b_empty); end
            end
            b_inc = 1'b1;
            step();
            mb = mb + 5'd1;
            eg = mb ^ (mb >> 1);
            checks++; if (b_gray !== eg) begin failures++; $display("FAIL sw_gray got=%b exp=%b", b_gray, eg); end
        end
        b_inc = 1'b0;
        checks++; if (b_gray !== 5'd0 || b_empty !== 1'b1 || b_raddr !== 4'd0) begin failures++; $display("FAIL sw_end got=%b/%0b/%0d exp=00000/1/0", b_gray, b_empty, b_raddr); end
    endtask

    initial begin
        test_reset();
        test_sync_read();
        test_underflow();
        test_full_wrap();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
